axi_ram_responder: RTL and testbench
====================================

# axi_ram_responder

AXI4 slave that answers the external-memory AXI master port of the SoC with an on-chip byte-writable RAM, standing in for the DDR controller in simulation and in FPGA builds without DDR. It accepts single-beat and burst reads and writes (AWLEN/ARLEN up to 255), serialises them onto one single-port RAM and returns AXI4 responses with the request ID. It sits at the far end of the `m_axi_*` bundle of one memory channel.

## Interface
Parameters:
- AXI_ID_W, 1: width of ID fields.
- AXI_ADDR_W, 14: byte address width.
- AXI_DATA_W, 32: data width; 32 or 64.
- MEM_ADDR_W, 12: RAM word address width; depth 2^MEM_ADDR_W words.

Ports (all AW/W/B/AR/R widths per AXI4; `s_axi_` prefix):
- clk  in  1  system clock.
- rst  in  1  reset: one clock; reset is asynchronous and active-low.
- s_axi_awid/awaddr/awlen/awsize/awburst  in  AXI_ID_W/AXI_ADDR_W/8/3/2  write address; awlock/awcache/awprot/awqos are accepted and ignored.
- s_axi_awvalid in 1; s_axi_awready out 1.
- s_axi_wdata/wstrb/wlast  in  AXI_DATA_W/AXI_DATA_W/8/1; s_axi_wvalid in 1; s_axi_wready out 1.
- s_axi_bid out AXI_ID_W; s_axi_bresp out 2; s_axi_bvalid out 1; s_axi_bready in 1.
- s_axi_arid/araddr/arlen/arsize/arburst  in  same widths as AW; lock/cache/prot/qos ignored; s_axi_arvalid in 1; s_axi_arready out 1.
- s_axi_rid out AXI_ID_W; s_axi_rdata out AXI_DATA_W; s_axi_rresp out 2; s_axi_rlast out 1; s_axi_rvalid out 1; s_axi_rready in 1.

## Operation
- FSM states: IDLE, WR_DATA, WR_RESP, RD_DATA. One transaction in flight at a time.
- IDLE: awready/arready high only in IDLE. If only AWVALID: take write. If only ARVALID: take read. Both: round-robin, write first after reset, then alternate with last granted.
- Address handling: word address = addr[MEM_ADDR_W+log2(AXI_DATA_W/8)-1 : log2(AXI_DATA_W/8)]; low byte bits ignored; upper bits beyond RAM depth ignored (aliasing, modulo depth).
- Burst: FIXED (00) keeps word address; INCR (01) and WRAP (10) both increment by one word per beat, wrapping modulo RAM depth. SIZE is ignored (always full-width beats). Reserved burst (11) treated as INCR with error response.
- WR_DATA: wready high; each W handshake writes wdata to RAM under wstrb byte enables; beat counter counts awlen+1 beats, counter alone ends the burst. wlast mismatch (wlast high before final beat, or low on final beat) latches error flag; data still written.
- WR_RESP: bvalid high, bid = latched awid, bresp = 2'b10 (SLVERR) if error flag or burst=11, else 2'b00. On bready, return to IDLE.
- RD_DATA: RAM read pipelined through a 2-entry output buffer so beats stream one per cycle while rready is high; rdata/rid/rresp/rlast held stable while rvalid && !rready. rlast high on beat arlen+1; rresp SLVERR for burst=11, else OKAY. After last R handshake, return to IDLE.

## Timing
- Reset (rst low, async): state IDLE, all valid/ready outputs 0, rdata 0, rid 0, bid 0, rresp 0, bresp 0, rlast 0, counters/flags 0. RAM contents not cleared. Reset mid-burst aborts transaction; no B or remaining R beats issued after reset release.
- First cycle after reset release: awready=arready=1.
- Write: AW handshake cycle T; wready high from T+1; last W beat at cycle L; bvalid high at L+1; next awready/arready at cycle after B handshake.
- Read: AR handshake T; first rvalid at T+2; with rready held high, beat n at T+2+n, burst of N beats finishes at T+1+N. Stall of rready any length loses no beat.
- RAM write visible to a read issued after the write's B handshake.

## Test plan
- Single write addr 0x10, data 0xDEADBEEF, wstrb 4'hF, then single read 0x10 -> bresp 00, bid = awid, rdata 0xDEADBEEF, rlast 1, rvalid at T+2.
- INCR write 8 beats (awlen 7) from 0x40 with data 1..8, INCR read 8 beats, rready always 1 -> 8 consecutive rvalid cycles, data 1..8, rlast only on 8th.
- Same read with rready toggled 1,0,0,1,... -> identical data sequence, outputs stable during stalls.
- Partial strobe: write 0xFFFFFFFF then 0x000000AA with wstrb 4'b0001 -> read 0xFFFFFFAA.
- Simultaneous AWVALID and ARVALID after reset -> write granted first, read next; repeat -> read granted first.
- Write awlen 3 with wlast on beat 2, and rst pulsed low during a 16-beat read -> first: bresp 2'b10, 4 beats written; second: all outputs 0 immediately, arready 1 after release.

Source files
------------

// File: rtl/axi_ram_responder.sv
// AXI4 slave backed by a single-port byte-writable RAM, serving one transaction at a time.
// Stands in for the DDR controller when no external memory is present.
module axi_ram_responder #(
    parameter int AXI_ID_W   = 1,
    parameter int AXI_ADDR_W = 14,
    parameter int AXI_DATA_W = 32,
    parameter int MEM_ADDR_W = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [AXI_ID_W-1:0]     s_axi_awid,
    input  logic [AXI_ADDR_W-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awlock,
    input  logic [3:0]              s_axi_awcache,
    input  logic [2:0]              s_axi_awprot,
    input  logic [3:0]              s_axi_awqos,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [AXI_DATA_W-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_W/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [AXI_ID_W-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [AXI_ID_W-1:0]     s_axi_arid,
    input  logic [AXI_ADDR_W-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arlock,
    input  logic [3:0]              s_axi_arcache,
    input  logic [2:0]              s_axi_arprot,
    input  logic [3:0]              s_axi_arqos,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [AXI_ID_W-1:0]     s_axi_rid,
    output logic [AXI_DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);
    localparam int NB    = AXI_DATA_W / 8;
    localparam int OFF   = $clog2(NB);
    localparam int DEPTH = 1 << MEM_ADDR_W;

    typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_t;

    state_t state, state_next;

    logic [AXI_DATA_W-1:0] mem [DEPTH];
    logic [AXI_DATA_W-1:0] mem_q;

    logic [MEM_ADDR_W-1:0] aw_word, ar_word, wr_addr, rd_addr, rd_word;
    logic [7:0]            wlen, wcnt, rd_left;
    logic [1:0]            wburst, rd_burst;
    logic                  werr, rd_err, prefer_rd;
    logic [AXI_ID_W-1:0]   bid_q, rid_q;
    logic                  aw_hs, ar_hs, mem_we, rd_issue, rd_issue_last;
    logic                  pend, pend_last, push, pop;
    logic [1:0]            occ, fill;
    logic                  wr_ptr, rd_ptr;
    logic [AXI_DATA_W-1:0] buf_data [2];
    logic                  buf_last [2];
    logic                  unused;

    assign aw_word = s_axi_awaddr[MEM_ADDR_W+OFF-1:OFF];
    assign ar_word = s_axi_araddr[MEM_ADDR_W+OFF-1:OFF];
    assign unused  = ^{s_axi_awaddr, s_axi_araddr, s_axi_awsize, s_axi_arsize,
                       s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                       s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};

    // Two-entry read buffer: a beat is issued to the RAM only if it will have a slot on arrival.
    assign push   = pend;
    assign pop    = s_axi_rvalid && s_axi_rready;
    assign fill   = occ + {1'b0, pend} - {1'b0, pop};
    assign aw_hs  = s_axi_awvalid && s_axi_awready;
    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign mem_we = (state == WR_DATA) && s_axi_wvalid;

    always_comb begin
        state_next    = state;
        s_axi_awready = 1'b0;
        s_axi_arready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_bresp   = 2'b00;
        rd_issue      = 1'b0;
        rd_word       = rd_addr;
        rd_issue_last = (rd_left == 8'd1);
        case (state)
            IDLE: begin
                // Contention is resolved by prefer_rd; a lone request is always accepted.
                s_axi_awready = rst && (!s_axi_arvalid || !prefer_rd);
                s_axi_arready = rst && (!s_axi_awvalid || prefer_rd);
                rd_word       = ar_word;
                rd_issue_last = (s_axi_arlen == 8'd0);
                rd_issue      = s_axi_arvalid && s_axi_arready;
                if (s_axi_awvalid && s_axi_awready)
                    state_next = WR_DATA;
                else if (s_axi_arvalid && s_axi_arready)
                    state_next = RD_DATA;
            end
            WR_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid && wcnt == wlen)
                    state_next = WR_RESP;
            end
            WR_RESP: begin
                s_axi_bvalid = 1'b1;
                s_axi_bresp  = werr ? 2'b10 : 2'b00;
                if (s_axi_bready)
                    state_next = IDLE;
            end
            RD_DATA: begin
                rd_issue = (rd_left != 8'd0) && (fill <= 2'd1);
                if (pop && s_axi_rlast)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // RAM contents survive reset, so the array lives in its own unreset process.
    always_ff @(posedge clk) begin
        if (mem_we)
            for (int b = 0; b < NB; b++)
                if (s_axi_wstrb[b])
                    mem[wr_addr][8*b +: 8] <= s_axi_wdata[8*b +: 8];
        if (rd_issue)
            mem_q <= mem[rd_word];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_addr   <= '0;
            wlen      <= '0;
            wcnt      <= '0;
            wburst    <= '0;
            werr      <= 1'b0;
            bid_q     <= '0;
            prefer_rd <= 1'b0;
        end else begin
            if (state == IDLE && s_axi_awvalid && s_axi_arvalid)
                prefer_rd <= !prefer_rd;
            if (aw_hs) begin
                bid_q   <= s_axi_awid;
                wr_addr <= aw_word;
                wlen    <= s_axi_awlen;
                wcnt    <= '0;
                wburst  <= s_axi_awburst;
                werr    <= (s_axi_awburst == 2'b11);
            end else if (mem_we) begin
                wcnt <= wcnt + 8'd1;
                if (wburst != 2'b00)
                    wr_addr <= wr_addr + MEM_ADDR_W'(1);
                if (s_axi_wlast != (wcnt == wlen))
                    werr <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_addr     <= '0;
            rd_left     <= '0;
            rd_burst    <= '0;
            rd_err      <= 1'b0;
            rid_q       <= '0;
            pend        <= 1'b0;
            pend_last   <= 1'b0;
            occ         <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_last[0] <= 1'b0;
            buf_last[1] <= 1'b0;
        end else begin
            if (ar_hs) begin
                rid_q    <= s_axi_arid;
                rd_err   <= (s_axi_arburst == 2'b11);
                rd_burst <= s_axi_arburst;
                rd_left  <= s_axi_arlen;
                rd_addr  <= ar_word + MEM_ADDR_W'(s_axi_arburst != 2'b00);
            end else if (rd_issue) begin
                rd_left <= rd_left - 8'd1;
                if (rd_burst != 2'b00)
                    rd_addr <= rd_addr + MEM_ADDR_W'(1);
            end
            pend      <= rd_issue;
            pend_last <= rd_issue_last;
            if (push) begin
                buf_data[wr_ptr] <= mem_q;
                buf_last[wr_ptr] <= pend_last;
                wr_ptr           <= !wr_ptr;
            end
            if (pop)
                rd_ptr <= !rd_ptr;
            occ <= fill;
        end
    end

    assign s_axi_rvalid = (occ != 2'd0);
    assign s_axi_rdata  = buf_data[rd_ptr];
    assign s_axi_rlast  = s_axi_rvalid && buf_last[rd_ptr];
    assign s_axi_rresp  = (s_axi_rvalid && rd_err) ? 2'b10 : 2'b00;
    assign s_axi_rid    = rid_q;
    assign s_axi_bid    = bid_q;

endmodule

// File: tb/tb_axi_ram_responder.sv
// Randomised and directed bench for axi_ram_responder against a word-array memory model.
module tb_axi_ram_responder;
    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [0:0]  awid, arid, bid, rid;
    logic [13:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize, awprot, arprot;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awlock, arlock;
    logic [3:0]  awcache, arcache, awqos, arqos;
    logic        awvalid, awready, arvalid, arready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;

    int checks = 0;
    int passes = 0;
    logic [31:0] model [DEPTH];

    always #5 clk = ~clk;

    axi_ram_responder dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
        .s_axi_awburst(awburst), .s_axi_awlock(awlock), .s_axi_awcache(awcache),
        .s_axi_awprot(awprot), .s_axi_awqos(awqos), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
        .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
        .s_axi_bready(bready), .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arlock(arlock),
        .s_axi_arcache(arcache), .s_axi_arprot(arprot), .s_axi_arqos(arqos),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_rid(rid), .s_axi_rdata(rdata),
        .s_axi_rresp(rresp), .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp)
            passes++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic int nextWord(input int w, input logic [1:0] burst);
        return (burst == 2'b00) ? w : (w + 1) % DEPTH;
    endfunction

    task automatic awPhase();
        int n = 0;
        awvalid = 1'b1;
        #1;
        while (!awready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        checkOutput("aw_accepted", n < 50, 1);
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic arPhase();
        int n = 0;
        arvalid = 1'b1;
        #1;
        while (!arready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        checkOutput("ar_accepted", n < 50, 1);
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic wPhase(input int len, input int last_at, input logic [1:0] burst,
                          input logic [13:0] addr, input int dmode, input logic [31:0] base,
                          input int smode, input logic [3:0] strb);
        int w = int'(addr >> 2) % DEPTH;
        int n;
        for (int b = 0; b <= len; b++) begin
            wvalid = 1'b1;
            wdata  = (dmode != 0) ? base + 32'(b) : $urandom;
            wstrb  = (smode != 0) ? 4'($urandom) : strb;
            wlast  = (b == last_at);
            #1;
            if (b == 0) checkOutput("wready_t1", wready, 1);
            n = 0;
            while (!wready && n < 50) begin
                @(negedge clk); #1; n++;
            end
            for (int i = 0; i < 4; i++)
                if (wstrb[i]) model[w][8*i +: 8] = wdata[8*i +: 8];
            w = nextWord(w, burst);
            @(negedge clk);
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic bPhase(input logic [0:0] id, input logic [1:0] exp_resp);
        int d = $urandom_range(0, 2);
        #1;
        checkOutput("bvalid_l1", bvalid, 1);
        checkOutput("bid", bid, id);
        checkOutput("bresp", bresp, exp_resp);
        for (int i = 0; i < d; i++) begin
            @(negedge clk); #1;
            checkOutput("bvalid_hold", bvalid, 1);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        #1;
        checkOutput("b_done", {bvalid, awready | arready}, 2'b01);
    endtask

    task automatic rPhase(input logic [0:0] id, input logic [13:0] addr, input int len,
                          input logic [1:0] burst, input int mode);
        int w = int'(addr >> 2) % DEPTH;
        int beat = 0, k = 0, gaps = 0;
        logic held = 1'b0;
        logic [31:0] hd = '0;
        logic hl = 1'b0;
        logic [1:0] er = (burst == 2'b11) ? 2'b10 : 2'b00;
        rready = 1'b0;
        #1;
        checkOutput("rvalid_t1", rvalid, 0);
        @(negedge clk);
        while (beat <= len && k < 3000) begin
            case (mode)
                0:       rready = 1'b1;
                1:       rready = (k % 3 == 0);
                default: rready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (k == 0) checkOutput("rvalid_t2", rvalid, 1);
            if (held) checkOutput("r_stable", {rvalid, rlast, rdata}, {1'b1, hl, hd});
            held = 1'b0;
            if (rvalid && rready) begin
                checkOutput("rdata", rdata, model[w]);
                checkOutput("rlast", rlast, beat == len);
                checkOutput("rid_rresp", {rid, rresp}, {id, er});
                w = nextWord(w, burst);
                beat++;
            end else if (rvalid) begin
                held = 1'b1;
                hd   = rdata;
                hl   = rlast;
            end else if (mode == 0) begin
                gaps++;
            end
            k++;
            @(negedge clk);
        end
        rready = 1'b0;
        #1;
        checkOutput("r_count", beat, len + 1);
        if (mode == 0) checkOutput("r_gaps", gaps, 0);
        checkOutput("r_done", {rvalid, awready | arready}, 2'b01);
    endtask

    task automatic applyWrite(input logic [0:0] id, input logic [13:0] addr, input int len,
                              input logic [1:0] burst, input int last_at, input int dmode,
                              input logic [31:0] base, input int smode, input logic [3:0] strb);
        awid = id; awaddr = addr; awlen = 8'(len); awburst = burst;
        awPhase();
        wPhase(len, last_at, burst, addr, dmode, base, smode, strb);
        bPhase(id, (burst == 2'b11 || last_at != len) ? 2'b10 : 2'b00);
    endtask

    task automatic applyRead(input logic [0:0] id, input logic [13:0] addr, input int len,
                             input logic [1:0] burst, input int mode);
        arid = id; araddr = addr; arlen = 8'(len); arburst = burst;
        arPhase();
        rPhase(id, addr, len, burst, mode);
    endtask

    task automatic applyStimulus();
        int len, stray;
        logic [1:0] burst;
        awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01; awlock = 1'b0;
        awcache = '0; awprot = '0; awqos = '0; awvalid = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01; arlock = 1'b0;
        arcache = '0; arprot = '0; arqos = '0; arvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_outputs", {awready, arready, wready, bvalid, rvalid, rlast, rresp,
                                      bresp, rid, bid, rdata}, '0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("ready_after_reset", {awready, arready}, 2'b11);

        // Contention straight after reset goes to the write, the next one to the read.
        awid = 1'b1; awaddr = 14'h100; awlen = 8'd0; awburst = 2'b01;
        arid = 1'b0; araddr = 14'h100; arlen = 8'd0; arburst = 2'b01;
        awvalid = 1'b1; arvalid = 1'b1;
        #1;
        checkOutput("arb_first_write", {awready, arready}, 2'b10);
        awPhase();
        wPhase(0, 0, 2'b01, 14'h100, 0, 0, 0, 4'hF);
        bPhase(1'b1, 2'b00);
        arPhase();
        rPhase(1'b0, 14'h100, 0, 2'b01, 0);
        awaddr = 14'h104;
        awvalid = 1'b1; arvalid = 1'b1;
        #1;
        checkOutput("arb_second_read", {awready, arready}, 2'b01);
        arPhase();
        rPhase(1'b0, 14'h100, 0, 2'b01, 0);
        awPhase();
        wPhase(0, 0, 2'b01, 14'h104, 0, 0, 0, 4'hF);
        bPhase(1'b1, 2'b00);

        for (int i = 0; i < 16; i++)
            applyWrite(1'b0, 14'(i * 1024), 255, 2'b01, 255, 0, 0, 0, 4'hF);

        applyWrite(1'b1, 14'h10, 0, 2'b01, 0, 1, 32'hDEADBEEF, 0, 4'hF);
        applyRead(1'b1, 14'h10, 0, 2'b01, 0);
        applyWrite(1'b0, 14'h40, 7, 2'b01, 7, 1, 32'd1, 0, 4'hF);
        applyRead(1'b0, 14'h40, 7, 2'b01, 0);
        applyRead(1'b1, 14'h40, 7, 2'b01, 1);
        applyWrite(1'b0, 14'h80, 0, 2'b01, 0, 1, 32'hFFFFFFFF, 0, 4'hF);
        applyWrite(1'b0, 14'h80, 0, 2'b01, 0, 1, 32'h000000AA, 0, 4'h1);
        applyRead(1'b0, 14'h80, 0, 2'b01, 0);
        applyWrite(1'b1, 14'h200, 3, 2'b01, 1, 0, 0, 0, 4'hF);
        applyRead(1'b1, 14'h200, 3, 2'b01, 2);
        applyWrite(1'b0, 14'h300, 2, 2'b01, -1, 0, 0, 0, 4'hF);
        applyWrite(1'b0, 14'h400, 3, 2'b00, 3, 0, 0, 0, 4'hF);
        applyRead(1'b0, 14'h400, 2, 2'b00, 2);
        applyWrite(1'b1, 14'h3FF8, 3, 2'b10, 3, 0, 0, 0, 4'hF);
        applyRead(1'b1, 14'h3FF9, 3, 2'b10, 0);
        applyWrite(1'b0, 14'h500, 1, 2'b11, 1, 0, 0, 0, 4'hF);
        applyRead(1'b0, 14'h500, 1, 2'b11, 0);

        repeat (30) begin
            len   = $urandom_range(0, 15);
            burst = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                applyWrite(1'($urandom), 14'($urandom), len, burst,
                           ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : len,
                           0, 0, 1, 4'h0);
            else
                applyRead(1'($urandom), 14'($urandom), len, burst, $urandom_range(0, 2));
        end

        // Reset in the middle of a 16-beat read must drop the remaining beats.
        arid = 1'b1; araddr = 14'h0; arlen = 8'd15; arburst = 2'b01;
        arPhase();
        rready = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("reset_mid", {awready, arready, wready, bvalid, rvalid, rlast, rresp,
                                  bresp, rid, bid, rdata}, '0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("arready_after_reset", {arready, rvalid}, 2'b10);
        stray = 0;
        repeat (20) begin
            @(negedge clk); #1;
            if (rvalid || bvalid) stray++;
        end
        checkOutput("no_stray_beats", stray, 0);
        rready = 1'b0;
        applyRead(1'b0, 14'h40, 7, 2'b01, 0);
    endtask

    initial begin
        applyStimulus();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
